// File: rtl/cache_refill_ctrl.sv
// ---------------------------------------------------------------------------
// cache_refill_ctrl
//
// Miss-handling controller for a direct-mapped data cache. It compares the
// requested tag with the tag/valid read-out, stalls the core on a miss,
// fetches the word from memory, writes it back into the cache with a
// one-cycle fill strobe, and runs a full-cache invalidate sweep on request.
//
// Handshake (memory side): oMemReq is raised in MEM_REQ and held, with
// oMemAddr stable, until the cycle iMemAck is seen high. iMemData is taken
// in that same cycle. iMemAck is ignored in every other state.
//
// Ports
//   iCLK, iRSTn            clock, asynchronous active-low reset
//   iReq, iAddress         core load access and byte address
//   iTag, iV               tag/valid read from the cache at the current index
//   iFlushAll              request a full-cache invalidate
//   iMemAck, iMemData      memory response
//   oHit, oStall           hit indication and core stall
//   oMemReq, oMemAddr      memory read request and word-aligned address
//   oFill, oFillIndex,
//   oFillTag, oFillData    one-cycle cache write
//   oFlushEn, oFlushAddress invalidate strobe and line index
//   oMissCount             saturating miss counter
//   oDbgState              current FSM state (0 IDLE,1 MEM_REQ,2 FILL,3 FLUSH)
// ---------------------------------------------------------------------------
module cache_refill_ctrl #(
  parameter int INDEX_WIDTH = 4,
  parameter int DATA_WIDTH  = 32,
  parameter int CNT_WIDTH   = 16
) (
  input  logic                   iCLK,
  input  logic                   iRSTn,
  input  logic                   iReq,
  input  logic [DATA_WIDTH-1:0]  iAddress,
  input  logic [25:0]            iTag,
  input  logic                   iV,
  input  logic                   iFlushAll,
  input  logic                   iMemAck,
  input  logic [DATA_WIDTH-1:0]  iMemData,
  output logic                   oHit,
  output logic                   oStall,
  output logic                   oMemReq,
  output logic [DATA_WIDTH-1:0]  oMemAddr,
  output logic                   oFill,
  output logic [INDEX_WIDTH-1:0] oFillIndex,
  output logic [25:0]            oFillTag,
  output logic [DATA_WIDTH-1:0]  oFillData,
  output logic                   oFlushEn,
  output logic [INDEX_WIDTH-1:0] oFlushAddress,
  output logic [CNT_WIDTH-1:0]   oMissCount,
  output logic [1:0]             oDbgState
);

  localparam int TAG_W = 26;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_MEM_REQ = 2'd1,
    S_FILL    = 2'd2,
    S_FLUSH   = 2'd3
  } state_t;

  state_t                 r_state;
  state_t                 w_next;
  logic [DATA_WIDTH-1:0]  r_miss_addr;
  logic [DATA_WIDTH-1:0]  r_fill_data;
  logic                   r_flush_pend;
  logic [INDEX_WIDTH-1:0] r_flush_cnt;
  logic [CNT_WIDTH-1:0]   r_miss_cnt;

  logic                   w_tag_match;
  logic                   w_flush_go;
  logic                   w_flush_last;
  logic                   w_miss_start;

  assign w_tag_match  = iV && (iTag == iAddress[DATA_WIDTH-1 -: TAG_W]);
  assign w_flush_go   = iFlushAll || r_flush_pend;
  assign w_flush_last = (r_flush_cnt == {INDEX_WIDTH{1'b1}});
  // A flush request in IDLE wins over a simultaneous access.
  assign w_miss_start = (r_state == S_IDLE) && !w_flush_go && iReq && !w_tag_match;

  // State register
  always_ff @(posedge iCLK or negedge iRSTn) begin
    if (!iRSTn) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_flush_go)        w_next = S_FLUSH;
        else if (w_miss_start) w_next = S_MEM_REQ;
      end
      S_MEM_REQ: if (iMemAck) w_next = S_FILL;
      S_FILL:    w_next = S_IDLE;
      S_FLUSH:   if (w_flush_last) w_next = S_IDLE;
      default:   w_next = S_IDLE;
    endcase
  end

  // Output logic. The iReq-dependent outputs are gated by iRSTn so that
  // everything reads 0 while reset is held, even with the core still asking.
  always_comb begin
    oHit     = 1'b0;
    oStall   = 1'b0;
    oMemReq  = 1'b0;
    oFill    = 1'b0;
    oFlushEn = 1'b0;
    case (r_state)
      S_IDLE: begin
        oHit   = iRSTn && iReq && w_tag_match;
        oStall = iRSTn && (w_flush_go || (iReq && !w_tag_match));
      end
      S_MEM_REQ: begin
        oMemReq = 1'b1;
        oStall  = 1'b1;
      end
      S_FILL: begin
        oFill  = 1'b1;
        oStall = 1'b1;
      end
      S_FLUSH: begin
        oFlushEn = 1'b1;
        oStall   = 1'b1;
      end
      default: ;
    endcase
  end

  // Datapath registers
  always_ff @(posedge iCLK or negedge iRSTn) begin
    if (!iRSTn) begin
      r_miss_addr  <= '0;
      r_fill_data  <= '0;
      r_flush_pend <= 1'b0;
      r_flush_cnt  <= '0;
      r_miss_cnt   <= '0;
    end else begin
      if (w_miss_start) begin
        r_miss_addr <= iAddress;
        if (r_miss_cnt != {CNT_WIDTH{1'b1}})
          r_miss_cnt <= r_miss_cnt + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
      end
      if ((r_state == S_MEM_REQ) && iMemAck)
        r_fill_data <= iMemData;
      // A flush arriving mid-refill is remembered; one arriving during the
      // sweep is absorbed.
      if (((r_state == S_MEM_REQ) || (r_state == S_FILL)) && iFlushAll)
        r_flush_pend <= 1'b1;
      else if ((r_state == S_FLUSH) && w_flush_last)
        r_flush_pend <= 1'b0;
      if (r_state == S_FLUSH)
        r_flush_cnt <= w_flush_last ? '0 : r_flush_cnt + {{(INDEX_WIDTH-1){1'b0}}, 1'b1};
    end
  end

  assign oMemAddr      = r_miss_addr & {{(DATA_WIDTH-2){1'b1}}, 2'b00};
  assign oFillIndex    = r_miss_addr[INDEX_WIDTH+1:2];
  assign oFillTag      = r_miss_addr[DATA_WIDTH-1 -: TAG_W];
  assign oFillData     = r_fill_data;
  assign oFlushAddress = r_flush_cnt;
  assign oMissCount    = r_miss_cnt;
  assign oDbgState     = r_state;

endmodule

// File: tb/tb_cache_refill_ctrl.sv
// ---------------------------------------------------------------------------
// tb_cache_refill_ctrl
//
// Directed bench for cache_refill_ctrl. A second instance with a 2-bit miss
// counter shares all inputs and shows counter saturation.
// ---------------------------------------------------------------------------
module tb_cache_refill_ctrl;

  logic        iCLK = 1'b0;
  logic        iRSTn;
  logic        iReq;
  logic [31:0] iAddress;
  logic [25:0] iTag;
  logic        iV;
  logic        iFlushAll;
  logic        iMemAck;
  logic [31:0] iMemData;

  logic        oHit, oStall, oMemReq, oFill, oFlushEn;
  logic [31:0] oMemAddr, oFillData;
  logic [3:0]  oFillIndex, oFlushAddress;
  logic [25:0] oFillTag;
  logic [15:0] oMissCount;
  logic [1:0]  oDbgState;

  logic        s_hit, s_stall, s_memreq, s_fill, s_flushen;
  logic [31:0] s_memaddr, s_filldata;
  logic [3:0]  s_fillindex, s_flushaddr;
  logic [25:0] s_filltag;
  logic [1:0]  s_misscount;
  logic [1:0]  s_state;

  int n_checks = 0;
  int n_errors = 0;
  int exp_miss = 0;

  // ---------------- clock / reset ----------------
  always #5 iCLK = ~iCLK;

  cache_refill_ctrl #(.INDEX_WIDTH(4), .DATA_WIDTH(32), .CNT_WIDTH(16)) u_dut (
    .iCLK(iCLK), .iRSTn(iRSTn), .iReq(iReq), .iAddress(iAddress), .iTag(iTag),
    .iV(iV), .iFlushAll(iFlushAll), .iMemAck(iMemAck), .iMemData(iMemData),
    .oHit(oHit), .oStall(oStall), .oMemReq(oMemReq), .oMemAddr(oMemAddr),
    .oFill(oFill), .oFillIndex(oFillIndex), .oFillTag(oFillTag),
    .oFillData(oFillData), .oFlushEn(oFlushEn), .oFlushAddress(oFlushAddress),
    .oMissCount(oMissCount), .oDbgState(oDbgState)
  );

  cache_refill_ctrl #(.INDEX_WIDTH(4), .DATA_WIDTH(32), .CNT_WIDTH(2)) u_sat (
    .iCLK(iCLK), .iRSTn(iRSTn), .iReq(iReq), .iAddress(iAddress), .iTag(iTag),
    .iV(iV), .iFlushAll(iFlushAll), .iMemAck(iMemAck), .iMemData(iMemData),
    .oHit(s_hit), .oStall(s_stall), .oMemReq(s_memreq), .oMemAddr(s_memaddr),
    .oFill(s_fill), .oFillIndex(s_fillindex), .oFillTag(s_filltag),
    .oFillData(s_filldata), .oFlushEn(s_flushen), .oFlushAddress(s_flushaddr),
    .oMissCount(s_misscount), .oDbgState(s_state)
  );

  // ---------------- checking ----------------
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Advance one clock and step 1 time unit past the edge before driving.
  task automatic cyc();
    @(posedge iCLK);
    #1;
  endtask

  task automatic idle_inputs();
    iReq = 1'b0; iAddress = '0; iTag = '0; iV = 1'b0;
    iFlushAll = 1'b0; iMemAck = 1'b0; iMemData = '0;
  endtask

  // One full miss: IDLE detect, lat MEM_REQ cycles (ack on the last), FILL,
  // then the core re-presents the access and it hits.
  task automatic do_miss(input logic [31:0] addr, input logic [25:0] tag_rd,
                         input logic v_rd, input logic [31:0] data, input int lat,
                         input logic [3:0] exp_idx, input logic [25:0] exp_tag);
    int stalls;
    stalls = 0;
    iReq = 1'b1; iAddress = addr; iTag = tag_rd; iV = v_rd; iMemAck = 1'b0;
    #1;
    chk("miss_idle_hit", oHit, 1'b0);
    chk("miss_idle_stall", oStall, 1'b1);
    chk("miss_idle_memreq", oMemReq, 1'b0);
    if (oStall) stalls++;
    exp_miss++;
    for (int k = 1; k <= lat; k++) begin
      cyc();
      iMemAck  = (k == lat);
      iMemData = (k == lat) ? data : 32'h0;
      #1;
      chk("memreq", oMemReq, 1'b1);
      chk("memaddr", oMemAddr, {addr[31:2], 2'b00});
      chk("misscount", oMissCount, exp_miss);
      if (oStall) stalls++;
    end
    cyc();
    iMemAck = 1'b0; iMemData = '0;
    #1;
    chk("fill", oFill, 1'b1);
    chk("fill_memreq", oMemReq, 1'b0);
    chk("fill_index", oFillIndex, exp_idx);
    chk("fill_tag", oFillTag, exp_tag);
    chk("fill_data", oFillData, data);
    if (oStall) stalls++;
    chk("stall_cycles", stalls, lat + 2);
    cyc();
    iTag = exp_tag; iV = 1'b1;
    #1;
    chk("rehit_hit", oHit, 1'b1);
    chk("rehit_stall", oStall, 1'b0);
    chk("rehit_fill", oFill, 1'b0);
    iReq = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    idle_inputs();
    iRSTn = 1'b0;
    iReq  = 1'b1;           // core asking during reset must not show
    iAddress = 32'h0000_2048;
    repeat (2) @(posedge iCLK);
    #1;
    chk("rst_stall", oStall, 1'b0);
    chk("rst_hit", oHit, 1'b0);
    chk("rst_memreq", oMemReq, 1'b0);
    chk("rst_fill", oFill, 1'b0);
    chk("rst_flushen", oFlushEn, 1'b0);
    chk("rst_misscount", oMissCount, 16'd0);
    chk("rst_memaddr", oMemAddr, 32'h0);
    chk("rst_state", oDbgState, 2'd0);
    idle_inputs();
    iRSTn = 1'b1;
    cyc();

    // Hit
    iReq = 1'b1; iAddress = 32'h0000_1044; iV = 1'b1; iTag = 26'h41;
    #1;
    chk("hit_hit", oHit, 1'b1);
    chk("hit_stall", oStall, 1'b0);
    cyc();
    chk("hit_memreq", oMemReq, 1'b0);
    chk("hit_misscount", oMissCount, 16'd0);
    idle_inputs();
    cyc();

    // Miss, 3-cycle memory
    do_miss(32'h0000_2048, 26'h0, 1'b0, 32'hDEAD_BEEF, 3, 4'd2, 26'h81);
    chk("miss1_count", oMissCount, 16'd1);
    cyc();

    // Tag mismatch with valid line, ack in first MEM_REQ cycle
    do_miss(32'h0000_0440, 26'h10, 1'b1, 32'h1234_5678, 1, 4'd0, 26'h11);
    cyc();

    // iMemAck while IDLE is ignored
    iMemAck = 1'b1; iMemData = 32'hFFFF_FFFF;
    cyc();
    chk("stray_ack_memreq", oMemReq, 1'b0);
    chk("stray_ack_fill", oFill, 1'b0);
    chk("stray_ack_filldata", oFillData, 32'h1234_5678);
    idle_inputs();
    cyc();

    // Flush requested during refill
    iReq = 1'b1; iAddress = 32'h0000_3000; iV = 1'b0; iTag = '0;
    #1;
    chk("fr_idle_stall", oStall, 1'b1);
    exp_miss++;
    cyc();
    iFlushAll = 1'b1;
    #1;
    chk("fr_memreq1", oMemReq, 1'b1);
    cyc();
    iFlushAll = 1'b0; iMemAck = 1'b1; iMemData = 32'hA5A5_A5A5;
    #1;
    chk("fr_memreq2", oMemReq, 1'b1);
    cyc();
    iMemAck = 1'b0; iMemData = '0;
    #1;
    chk("fr_fill", oFill, 1'b1);
    chk("fr_fill_data", oFillData, 32'hA5A5_A5A5);
    chk("fr_fill_flushen", oFlushEn, 1'b0);
    cyc();
    iV = 1'b1; iTag = 26'hC0;   // core re-presents; flush must win
    #1;
    chk("fr_idle_prio_stall", oStall, 1'b1);
    chk("fr_idle_prio_flushen", oFlushEn, 1'b0);
    chk("fr_idle_prio_memreq", oMemReq, 1'b0);
    for (int i = 0; i < 16; i++) begin
      cyc();
      iFlushAll = (i == 5);     // absorbed, must not extend the sweep
      #1;
      chk("fr_flushen", oFlushEn, 1'b1);
      chk("fr_flushaddr", oFlushAddress, i);
      chk("fr_flush_stall", oStall, 1'b1);
      chk("fr_flush_hit", oHit, 1'b0);
    end
    cyc();
    iFlushAll = 1'b0;
    #1;
    chk("fr_done_flushen", oFlushEn, 1'b0);
    chk("fr_done_stall", oStall, 1'b0);
    chk("fr_done_hit", oHit, 1'b1);
    chk("fr_misscount", oMissCount, exp_miss);
    idle_inputs();
    cyc();

    // Flush from IDLE beats a simultaneous miss
    iReq = 1'b1; iAddress = 32'h0000_5000; iV = 1'b0; iFlushAll = 1'b1;
    #1;
    chk("fi_stall", oStall, 1'b1);
    cyc();
    idle_inputs();
    #1;
    chk("fi_flushen0", oFlushEn, 1'b1);
    chk("fi_flushaddr0", oFlushAddress, 4'd0);
    chk("fi_misscount", oMissCount, exp_miss);
    for (int i = 1; i < 16; i++) begin
      cyc();
      chk("fi_flushaddr", oFlushAddress, i);
    end
    cyc();
    chk("fi_done_flushen", oFlushEn, 1'b0);
    chk("fi_done_state", oDbgState, 2'd0);

    // Two more misses: 2-bit counter instance saturates at 3
    do_miss(32'h0000_0104, 26'h0, 1'b0, 32'h0000_0001, 2, 4'd1, 26'h4);
    cyc();
    do_miss(32'hFFFF_FFFC, 26'h0, 1'b0, 32'h0BAD_F00D, 1, 4'hF, 26'h3FF_FFFF);
    chk("main_count5", oMissCount, 16'd5);
    chk("sat_count", s_misscount, 2'd3);
    cyc();

    // Asynchronous reset in the middle of MEM_REQ
    iReq = 1'b1; iAddress = 32'h0000_7010; iV = 1'b0;
    cyc();
    chk("ar_memreq_before", oMemReq, 1'b1);
    #2;
    iRSTn = 1'b0;
    #1;
    chk("ar_memreq", oMemReq, 1'b0);
    chk("ar_stall", oStall, 1'b0);
    chk("ar_fill", oFill, 1'b0);
    chk("ar_misscount", oMissCount, 16'd0);
    exp_miss = 0;
    cyc();
    idle_inputs();
    iRSTn = 1'b1;
    iMemAck = 1'b1; iMemData = 32'hCAFE_0000;   // late ack
    cyc();
    chk("late_ack_memreq", oMemReq, 1'b0);
    chk("late_ack_fill", oFill, 1'b0);
    cyc();
    chk("late_ack_fill2", oFill, 1'b0);
    chk("late_ack_filldata", oFillData, 32'h0);
    chk("post_rst_count", oMissCount, exp_miss);
    chk("post_rst_sat", s_misscount, 2'd0);
    idle_inputs();

    // ---------------- report ----------------
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/cache_refill_ctrl.md
Name: cache_refill_ctrl

Overview:
Miss-handling controller for the direct-mapped data cache. It sits between the cache arrays and data memory. It compares the requested tag against the cache's tag/valid read-out, stalls the core on a miss, and fetches the word from memory over a req/ack handshake. It then drives a one-cycle fill strobe into the cache, and also sequences a full-cache invalidate sweep on request.

Parameters:
INDEX_WIDTH, 4, number of index bits; the cache has 2**INDEX_WIDTH lines.
DATA_WIDTH, 32, address and data word width.
CNT_WIDTH, 16, width of the saturating miss counter.

Ports:
iCLK  input  1  clock, all state updates on rising edge
iRSTn  input  1  asynchronous active-low reset
iReq  input  1  core load access valid this cycle
iAddress  input  DATA_WIDTH  core byte address; index = [INDEX_WIDTH+1:2], tag = [31:6]
iTag  input  26  tag read from cache at current index
iV  input  1  valid bit read from cache at current index
iFlushAll  input  1  request full-cache invalidate (pulse or level)
iMemAck  input  1  memory response valid; iMemData valid this cycle
iMemData  input  DATA_WIDTH  memory read data
oHit  output  1  combinational: IDLE && iReq && iV && iTag==iAddress[31:6]
oStall  output  1  core must hold its request
oMemReq  output  1  memory read request, held until ack
oMemAddr  output  DATA_WIDTH  latched miss address with bits [1:0] forced to 0
oFill  output  1  one-cycle cache write strobe
oFillIndex  output  INDEX_WIDTH  line index to write
oFillTag  output  26  tag to write
oFillData  output  DATA_WIDTH  data to write
oFlushEn  output  1  invalidate strobe for line oFlushAddress
oFlushAddress  output  INDEX_WIDTH  line being invalidated
oMissCount  output  CNT_WIDTH  saturating count of misses

Behaviour:
- States: IDLE, MEM_REQ, FILL, FLUSH. Reset state is IDLE.
- Reset values: all outputs 0, miss address register 0, fill data register 0, flush-pending flag 0, flush counter 0. Reset is asynchronous: asserting iRSTn low drops oMemReq, oFill and oFlushEn immediately, mid-transaction included. A late iMemAck after reset is ignored.
- IDLE:
  - If iFlushAll or flush-pending is set, go to FLUSH. Flush takes priority over iReq, and oStall=1 in that cycle.
  - Else if iReq and hit: oHit=1, oStall=0, stay in IDLE.
  - Else if iReq and miss: oStall=1 combinationally. Latch iAddress, increment oMissCount (saturates at all-ones), go to MEM_REQ.
- MEM_REQ:
  - oMemReq=1, oStall=1. oMemAddr is stable for the whole state.
  - On iMemAck, capture iMemData and go to FILL.
  - No timeout. Ack in the first MEM_REQ cycle is legal.
- FILL: lasts exactly 1 cycle.
  - oFill=1, oStall=1.
  - oFillIndex and oFillTag come from the latched address. oFillData is the captured word.
  - Next state is IDLE. The core re-presents the same access and hits.
- Miss latency from the iReq cycle: 1 (IDLE) + N (MEM_REQ, ack in its Nth cycle) + 1 (FILL), then the hit cycle.
- iFlushAll in MEM_REQ or FILL sets flush-pending. The refill completes first, then FLUSH is entered from IDLE. iFlushAll while already in FLUSH is absorbed and does not extend the sweep.
- FLUSH:
  - Lasts 2**INDEX_WIDTH cycles with oFlushEn=1 and oStall=1. oFlushAddress = 0,1,...,2**INDEX_WIDTH-1.
  - On the last index: clear flush-pending and the counter, return to IDLE.
  - iReq is ignored throughout.
- iMemAck outside MEM_REQ is ignored.
- oHit is 0 in every state other than IDLE.

Test Plan:
- Reset: drive iRSTn=0 mid-MEM_REQ -> oMemReq, oStall, oFill drop to 0 immediately. After release the FSM is in IDLE and oMissCount=0.
- Hit: iReq=1, iAddress=0x0000_1044, iV=1, iTag=0x41 -> oHit=1, oStall=0, oMemReq stays 0, oMissCount unchanged.
- Miss with 3-cycle memory: iAddress=0x0000_2048, iV=0, ack with iMemData=0xDEADBEEF on the 3rd MEM_REQ cycle:
  - oMemAddr=0x0000_2048 during MEM_REQ.
  - Then one FILL cycle with oFillIndex=2, oFillTag=0x81, oFillData=0xDEADBEEF.
  - oStall is high for 5 cycles; oMissCount=1.
- Tag mismatch: iV=1, iTag=0x10, iAddress tag 0x11 -> treated as a miss, oMemReq asserted next cycle.
- Flush during refill: assert iFlushAll in MEM_REQ -> refill completes normally. FLUSH follows with oFlushEn high for 16 cycles, oFlushAddress 0..15; then back to IDLE with oStall=0.
- Counter saturation: preload by 65535 misses (or CNT_WIDTH=2 with 5 misses) -> oMissCount holds at all-ones.
